// File: rtl/memory_controller.sv
// CPU-facing memory controller: 16K-word RAM, 8K-word VRAM shared with a video
// reader through a single port, and a read-only keyboard register.
module memory_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_load,
  input  logic [15:0] mem_wdata,
  output logic        mem_busy,
  output logic [15:0] mem_rdata,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_valid,
  input  logic [15:0] kbd_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN1   = 3'd1,
    DRAIN2   = 3'd2,
    VID_ADDR = 3'd3,
    VID_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_VRAM = 2'd1,
    REGION_KBD  = 2'd2,
    REGION_NONE = 2'd3
  } region_t;

  state_t      state_r;
  state_t      next_state_s;
  region_t     region_s;
  logic [15:0] ram_mem  [0:16383];
  logic [15:0] vram_mem [0:8191];
  logic [12:0] vram_addr_s;
  logic [15:0] vram_rd_s;
  logic        ram_we_s;
  logic        vram_we_s;
  logic [15:0] mem_rdata_r;
  logic [15:0] vid_rdata_r;
  logic        unused_s;

  // Bit 15 takes no part in decoding, so the upper half aliases the lower.
  assign unused_s = mem_address[15];

  // Address decode on the low 15 address bits.
  always_comb begin
    region_s = REGION_NONE;
    if (mem_address[14] == 1'b0) begin
      region_s = REGION_RAM;
    end else if (mem_address[13] == 1'b0) begin
      region_s = REGION_VRAM;
    end else if (mem_address[12:0] == 13'h0000) begin
      region_s = REGION_KBD;
    end else begin
      region_s = REGION_NONE;
    end
  end

  // The video reader owns the VRAM port only in VID_ADDR; the drain states keep it on the CPU.
  assign vram_addr_s = (state_r == VID_ADDR) ? vid_addr : mem_address[12:0];
  assign vram_rd_s   = vram_mem[vram_addr_s];
  assign ram_we_s    = mem_load && (region_s == REGION_RAM);
  assign vram_we_s   = mem_load && (region_s == REGION_VRAM) && (state_r == IDLE);

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Arbiter next-state logic.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (vid_req) begin
          next_state_s = DRAIN1;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAIN1:   next_state_s = DRAIN2;
      DRAIN2:   next_state_s = VID_ADDR;
      VID_ADDR: next_state_s = VID_DATA;
      VID_DATA: next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Storage arrays; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_mem[mem_address[13:0]] <= mem_wdata;
    end
    if (vram_we_s) begin
      vram_mem[vram_addr_s] <= mem_wdata;
    end
  end

  // Registered read data; array reads see pre-write contents at a write edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata_r <= 16'h0000;
      vid_rdata_r <= 16'h0000;
    end else begin
      case (region_s)
        REGION_RAM:  mem_rdata_r <= ram_mem[mem_address[13:0]];
        REGION_VRAM: begin
          // While the port serves the video reader the CPU's VRAM word is unavailable.
          if (state_r != VID_ADDR) begin
            mem_rdata_r <= vram_rd_s;
          end else begin
            mem_rdata_r <= mem_rdata_r;
          end
        end
        REGION_KBD:  mem_rdata_r <= kbd_code;
        default:     mem_rdata_r <= 16'h0000;
      endcase
      if (state_r == VID_ADDR) begin
        vid_rdata_r <= vram_rd_s;
      end else begin
        vid_rdata_r <= vid_rdata_r;
      end
    end
  end

  assign mem_busy  = (state_r != IDLE);
  assign vid_valid = (state_r == VID_DATA);
  assign mem_rdata = mem_rdata_r;
  assign vid_rdata = vid_rdata_r;

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller.
module tb_memory_controller;

  logic        clk;
  logic        reset;
  logic [15:0] mem_address;
  logic        mem_load;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic [15:0] mem_rdata;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        vid_valid;
  logic [15:0] kbd_code;

  int errors;
  int checks;

  memory_controller dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_wdata   (mem_wdata),
    .mem_busy    (mem_busy),
    .mem_rdata   (mem_rdata),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_rdata   (vid_rdata),
    .vid_valid   (vid_valid),
    .kbd_code    (kbd_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    mem_address = addr;
    mem_wdata   = data;
    mem_load    = 1'b1;
    tick();
    mem_load    = 1'b0;
  endtask

  // Present an address for one edge and compare the registered result.
  task automatic cpu_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    mem_address = addr;
    tick();
    check(tag, mem_rdata, exp);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    mem_address = 16'h0000;
    mem_load    = 1'b0;
    mem_wdata   = 16'h0000;
    vid_req     = 1'b0;
    vid_addr    = 13'h0000;
    kbd_code    = 16'h0000;
    tick();
    tick();
    check("reset_busy",   {15'd0, mem_busy},  16'h0000);
    check("reset_rdata",  mem_rdata,          16'h0000);
    check("reset_vrdata", vid_rdata,          16'h0000);
    check("reset_vvalid", {15'd0, vid_valid}, 16'h0000);
    reset = 1'b0;

    // RAM write then read, plus read-during-write returns old data.
    cpu_write(16'h0010, 16'h1234);
    check("ram_wr_busy", {15'd0, mem_busy}, 16'h0000);
    cpu_read("ram_rd", 16'h0010, 16'h1234);
    check("ram_rd_busy", {15'd0, mem_busy}, 16'h0000);
    cpu_write(16'h0010, 16'h5678);
    check("ram_rdw_old", mem_rdata, 16'h1234);
    cpu_read("ram_rdw_new", 16'h0010, 16'h5678);

    // Seed words that a faulty decode could alias onto.
    cpu_write(16'h3FFF, 16'h1111);
    cpu_write(16'h2000, 16'h3333);
    cpu_write(16'h5FFF, 16'h2222);
    cpu_write(16'h4000, 16'h00FF);
    cpu_write(16'h4001, 16'h0101);
    cpu_write(16'h4100, 16'hBEEF);

    // Keyboard, unmapped and aliased addresses.
    kbd_code = 16'h0041;
    cpu_read("kbd_rd", 16'h6000, 16'h0041);
    cpu_write(16'h6000, 16'hDEAD);
    cpu_write(16'h7FFF, 16'hDEAD);
    cpu_read("unmapped_rd", 16'h7FFF, 16'h0000);
    cpu_read("kbd_rd_after_wr", 16'h6000, 16'h0041);
    cpu_read("no_alias_3fff", 16'h3FFF, 16'h1111);
    cpu_read("no_alias_2000", 16'h2000, 16'h3333);
    cpu_read("no_alias_5fff", 16'h5FFF, 16'h2222);
    cpu_read("no_alias_4000", 16'h4000, 16'h00FF);
    cpu_write(16'h8005, 16'hA5A5);
    cpu_read("alias_rd_0005", 16'h0005, 16'hA5A5);
    cpu_read("alias_rd_8005", 16'h8005, 16'hA5A5);
    cpu_read("vram_rd_4100", 16'h4100, 16'hBEEF);

    // Video read from IDLE; RAM stays readable while busy.
    mem_address = 16'h0010;
    vid_addr    = 13'h0100;
    vid_req     = 1'b1;
    check("vid_idle_busy", {15'd0, mem_busy}, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("vid_busy_%0d", k),  {15'd0, mem_busy},  16'h0001);
      check($sformatf("vid_valid_%0d", k), {15'd0, vid_valid}, (k == 4) ? 16'h0001 : 16'h0000);
      if (k == 2) check("ram_rd_while_busy", mem_rdata, 16'h5678);
    end
    check("vid_rdata", vid_rdata, 16'hBEEF);
    vid_req = 1'b0;
    tick();
    check("vid_done_busy",  {15'd0, mem_busy},  16'h0000);
    check("vid_done_valid", {15'd0, vid_valid}, 16'h0000);

    // Race: CPU VRAM read in the last busy-low cycle, then grant.
    mem_address = 16'h4000;
    vid_req     = 1'b1;
    tick();
    tick();
    tick();
    check("race_rdata_l3", mem_rdata, 16'h00FF);
    tick();
    check("race_vid_valid", {15'd0, vid_valid}, 16'h0001);
    check("race_vid_rdata", vid_rdata, 16'hBEEF);
    vid_req = 1'b0;
    tick();
    check("race_idle_busy", {15'd0, mem_busy}, 16'h0000);
    cpu_read("race_vram0_kept", 16'h4000, 16'h00FF);
    cpu_read("race_vram100_kept", 16'h4100, 16'hBEEF);

    // VRAM write while busy is dropped; the same write in IDLE commits.
    vid_req = 1'b1;
    tick();
    check("gate_busy", {15'd0, mem_busy}, 16'h0001);
    cpu_write(16'h4001, 16'h9999);
    tick();
    tick();
    vid_req = 1'b0;
    tick();
    check("gate_idle", {15'd0, mem_busy}, 16'h0000);
    cpu_read("gate_busy_dropped", 16'h4001, 16'h0101);
    cpu_write(16'h4001, 16'h9999);
    check("gate_idle_rdw_old", mem_rdata, 16'h0101);
    cpu_read("gate_idle_commit", 16'h4001, 16'h9999);

    // Reset during DRAIN2 aborts the grant; held request is re-accepted.
    mem_address = 16'h0010;
    vid_req     = 1'b1;
    tick();
    tick();
    check("abort_drain2_busy", {15'd0, mem_busy}, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",   {15'd0, mem_busy},  16'h0000);
    check("abort_valid",  {15'd0, vid_valid}, 16'h0000);
    check("abort_rdata",  mem_rdata,          16'h0000);
    check("abort_vrdata", vid_rdata,          16'h0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("reacc_busy_%0d", k),  {15'd0, mem_busy},  16'h0001);
      check($sformatf("reacc_valid_%0d", k), {15'd0, vid_valid}, (k == 4) ? 16'h0001 : 16'h0000);
    end
    check("reacc_vid_rdata", vid_rdata, 16'hBEEF);
    vid_req = 1'b0;
    tick();
    check("reacc_done_busy", {15'd0, mem_busy}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
